// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the MIPS-subset CPU.
// Sequences FETCH/DECODE/EXEC/MEM/WB over a shared ALU and one memory port.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      Instr,
  input  logic             Zero,
  input  logic             MemAck,
  output logic             MemReq,
  output logic             MemWr,
  output logic             IorD,
  output logic             IRWr,
  output logic             PCWr,
  output logic [1:0]       PCSrc,
  output logic             TargetWr,
  output logic             RegWr,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemToReg,
  output logic             ALUsrcA,
  output logic [1:0]       ALUsrcB,
  output logic [2:0]       ALUcntrl,
  output logic             Trap,
  output logic [1:0]       TrapCause,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  state_t           state;
  state_t           next;
  logic [7:0]       wait_ctr;
  logic [1:0]       cause;
  logic [1:0]       cause_next;
  logic [CNT_W-1:0] count;

  logic [5:0] op;
  logic [5:0] funct;
  logic       rtype;
  logic       is_add;
  logic       is_slt;
  logic       is_jr;
  logic       is_addi;
  logic       is_beq;
  logic       is_bne;
  logic       is_lw;
  logic       is_sw;
  logic       is_jal;
  logic       legal;
  logic       mem_wait;
  logic       timeout;
  logic       unused;

  assign op     = Instr[31:26];
  assign funct  = Instr[5:0];
  assign unused = ^Instr[25:6];

  assign rtype   = (op == 6'b000000);
  assign is_add  = rtype && (funct == 6'b100000 || funct == 6'b100001);
  assign is_slt  = rtype && (funct == 6'b101010);
  assign is_jr   = rtype && (funct == 6'b001000);
  assign is_addi = (op == 6'b001000) || (op == 6'b001001);
  assign is_beq  = (op == 6'b000100);
  assign is_bne  = (op == 6'b000101);
  assign is_lw   = (op == 6'b100011);
  assign is_sw   = (op == 6'b101011);
  assign is_jal  = (op == 6'b000011);

  assign legal = is_add | is_slt | is_jr | is_addi | is_beq |
                 is_bne | is_lw | is_sw | is_jal;

  // Ack in the cycle the counter reads MEM_TIMEOUT-1 still wins.
  assign mem_wait = (state == FETCH) || (state == MEM);
  assign timeout  = mem_wait && !MemAck &&
                    (wait_ctr == 8'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cause    <= 2'd0;
      count    <= '0;
      wait_ctr <= 8'd0;
    end else begin
      state <= next;
      cause <= cause_next;
      if (state == FETCH && MemAck)
        count <= count + CNT_W'(1);
      if (mem_wait && !MemAck && !timeout)
        wait_ctr <= wait_ctr + 8'd1;
      else
        wait_ctr <= 8'd0;
    end
  end

  always_comb begin
    next       = state;
    cause_next = cause;
    MemReq     = 1'b0;
    MemWr      = 1'b0;
    IorD       = 1'b0;
    IRWr       = 1'b0;
    PCWr       = 1'b0;
    PCSrc      = 2'd0;
    TargetWr   = 1'b0;
    RegWr      = 1'b0;
    RegDst     = 2'd0;
    MemToReg   = 2'd0;
    ALUsrcA    = 1'b0;
    ALUsrcB    = 2'd0;
    ALUcntrl   = 3'd0;
    unique case (state)
      IDLE: next = FETCH;
      FETCH: begin
        MemReq  = 1'b1;
        ALUsrcB = 2'd1;
        if (MemAck) begin
          IRWr = 1'b1;
          PCWr = 1'b1;
          next = DECODE;
        end else if (timeout) begin
          next       = TRAP;
          cause_next = 2'd2;
        end
      end
      DECODE: begin
        ALUsrcB  = 2'd3;
        TargetWr = 1'b1;
        if (legal) begin
          next = EXEC;
        end else begin
          next       = TRAP;
          cause_next = 2'd1;
        end
      end
      EXEC: begin
        unique case (1'b1)
          is_add, is_slt: begin
            ALUsrcA  = 1'b1;
            ALUcntrl = is_slt ? 3'd3 : 3'd0;
            next     = WB;
          end
          is_addi, is_lw, is_sw: begin
            ALUsrcA = 1'b1;
            ALUsrcB = 2'd2;
            next    = is_addi ? WB : MEM;
          end
          is_beq, is_bne: begin
            ALUsrcA  = 1'b1;
            ALUcntrl = 3'd1;
            PCSrc    = 2'd1;
            PCWr     = is_beq ? Zero : ~Zero;
            next     = FETCH;
          end
          is_jr: begin
            PCSrc = 2'd3;
            PCWr  = 1'b1;
            next  = FETCH;
          end
          is_jal: begin
            RegWr    = 1'b1;
            RegDst   = 2'd2;
            MemToReg = 2'd2;
            PCSrc    = 2'd2;
            PCWr     = 1'b1;
            next     = FETCH;
          end
          default: begin
            next       = TRAP;
            cause_next = 2'd1;
          end
        endcase
      end
      MEM: begin
        MemReq = 1'b1;
        IorD   = 1'b1;
        MemWr  = is_sw;
        if (MemAck) begin
          next = is_sw ? FETCH : WB;
        end else if (timeout) begin
          next       = TRAP;
          cause_next = 2'd2;
        end
      end
      WB: begin
        RegWr = 1'b1;
        if (is_lw)
          MemToReg = 2'd1;
        else if (!is_addi)
          RegDst = 2'd1;
        next = FETCH;
      end
      TRAP: next = TRAP;
      default: next = IDLE;
    endcase
  end

  assign Trap       = (state == TRAP);
  assign TrapCause  = cause;
  assign State      = state;
  assign InstrCount = count;

endmodule
